// File: rtl/mem_arb_if.sv
// mem_arb_if: bundles the two requester ports, the shared read-data return
// and the single core memory port used by mem_arbiter.
// slave  : arbiter side.
// master : requesters plus memory model side.
interface mem_arb_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  p0_req;
    logic [1:0]            p0_action;
    logic [DATA_WIDTH-1:0] p0_addr;
    logic [DATA_WIDTH-1:0] p0_wdata;
    logic                  p0_gnt;
    logic                  p0_rvalid;

    logic                  p1_req;
    logic [1:0]            p1_action;
    logic [DATA_WIDTH-1:0] p1_addr;
    logic [DATA_WIDTH-1:0] p1_wdata;
    logic                  p1_gnt;
    logic                  p1_rvalid;

    logic [DATA_WIDTH-1:0] rdata;

    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [DATA_WIDTH-1:0] mem_r_addr;
    logic [DATA_WIDTH-1:0] mem_w_addr;
    logic [DATA_WIDTH-1:0] mem_w_data;
    logic [DATA_WIDTH-1:0] mem_r_data;

    modport slave (
        input  p0_req, p0_action, p0_addr, p0_wdata,
        input  p1_req, p1_action, p1_addr, p1_wdata,
        input  mem_r_data,
        output p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata,
        output mem_r_en, mem_w_en, mem_r_addr, mem_w_addr, mem_w_data
    );

    modport master (
        output p0_req, p0_action, p0_addr, p0_wdata,
        output p1_req, p1_action, p1_addr, p1_wdata,
        output mem_r_data,
        input  p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, rdata,
        input  mem_r_en, mem_w_en, mem_r_addr, mem_w_addr, mem_w_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one core memory port between instruction fetch (port 0)
// and load/store (port 1). One access at a time; reads wait RD_LAT cycles and
// the captured data is returned with a one-cycle rvalid pulse to the winner.
// Build macro MEM_ARB_FIXED_PRIO_EN: port 1 always wins when both request
// (default build: round-robin against the last granted port).
module mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LAT     = 1
) (
    input logic      clk,
    input logic      rst,
    mem_arb_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_gnt_q, last_gnt_d;
    logic                  win_q, win_d;
    logic                  wr_q, wr_d;
    logic [2:0]            cnt_q, cnt_d;

    logic                  p0_gnt_q, p0_gnt_d;
    logic                  p1_gnt_q, p1_gnt_d;
    logic                  p0_rvalid_q, p0_rvalid_d;
    logic                  p1_rvalid_q, p1_rvalid_d;
    logic                  mem_r_en_q, mem_r_en_d;
    logic                  mem_w_en_q, mem_w_en_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_w_data_q, mem_w_data_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  p0_valid_s;
    logic                  p1_valid_s;
    logic                  pick_s;
    logic [1:0]            sel_action_s;
    logic [DATA_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;

    // Qualify requests (action 00 is not a request) and choose the winner.
    always_comb begin
        p0_valid_s = bus.p0_req & (bus.p0_action != 2'b00);
        p1_valid_s = bus.p1_req & (bus.p1_action != 2'b00);
        if (p0_valid_s && p1_valid_s) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            pick_s = 1'b1;
`else
            pick_s = ~last_gnt_q;
`endif
        end else begin
            pick_s = p1_valid_s;
        end
        if (pick_s) begin
            sel_action_s = bus.p1_action;
            sel_addr_s   = bus.p1_addr;
            sel_wdata_s  = bus.p1_wdata;
        end else begin
            sel_action_s = bus.p0_action;
            sel_addr_s   = bus.p0_addr;
            sel_wdata_s  = bus.p0_wdata;
        end
    end

    // FSM next state, latched access info and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        last_gnt_d   = last_gnt_q;
        win_d        = win_q;
        wr_d         = wr_q;
        cnt_d        = cnt_q;
        p0_gnt_d     = 1'b0;
        p1_gnt_d     = 1'b0;
        p0_rvalid_d  = 1'b0;
        p1_rvalid_d  = 1'b0;
        mem_r_en_d   = 1'b0;
        mem_w_en_d   = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_w_data_d = mem_w_data_q;
        rdata_d      = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (p0_valid_s || p1_valid_s) begin
                    // Outputs are registered, so the ISSUE-cycle values are loaded here.
                    win_d        = pick_s;
                    last_gnt_d   = pick_s;
                    wr_d         = sel_action_s[1];
                    p0_gnt_d     = ~pick_s;
                    p1_gnt_d     = pick_s;
                    mem_r_en_d   = sel_action_s[0] & ~sel_action_s[1];
                    mem_w_en_d   = sel_action_s[1];
                    mem_addr_d   = sel_addr_s;
                    mem_w_data_d = sel_wdata_s;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (wr_q) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d   = 3'(RD_LAT);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd1) begin
                    // Memory data is valid this cycle; capture it and flag the winner.
                    cnt_d       = 3'd0;
                    rdata_d     = bus.mem_r_data;
                    p0_rvalid_d = ~win_q;
                    p1_rvalid_d = win_q;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, arbitration history and output registers; reset drops any read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_gnt_q   <= 1'b1;
            win_q        <= 1'b0;
            wr_q         <= 1'b0;
            cnt_q        <= 3'd0;
            p0_gnt_q     <= 1'b0;
            p1_gnt_q     <= 1'b0;
            p0_rvalid_q  <= 1'b0;
            p1_rvalid_q  <= 1'b0;
            mem_r_en_q   <= 1'b0;
            mem_w_en_q   <= 1'b0;
            mem_addr_q   <= {DATA_WIDTH{1'b0}};
            mem_w_data_q <= {DATA_WIDTH{1'b0}};
            rdata_q      <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            last_gnt_q   <= last_gnt_d;
            win_q        <= win_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            p0_gnt_q     <= p0_gnt_d;
            p1_gnt_q     <= p1_gnt_d;
            p0_rvalid_q  <= p0_rvalid_d;
            p1_rvalid_q  <= p1_rvalid_d;
            mem_r_en_q   <= mem_r_en_d;
            mem_w_en_q   <= mem_w_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_w_data_q <= mem_w_data_d;
            rdata_q      <= rdata_d;
        end
    end

    assign bus.p0_gnt     = p0_gnt_q;
    assign bus.p1_gnt     = p1_gnt_q;
    assign bus.p0_rvalid  = p0_rvalid_q;
    assign bus.p1_rvalid  = p1_rvalid_q;
    assign bus.rdata      = rdata_q;
    assign bus.mem_r_en   = mem_r_en_q;
    assign bus.mem_w_en   = mem_w_en_q;
    assign bus.mem_r_addr = mem_addr_q;
    assign bus.mem_w_addr = mem_addr_q;
    assign bus.mem_w_data = mem_w_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table against an RD_LAT=1 instance, plus
// hand-written sequences for reset during a read and an RD_LAT=3 instance.
module tb_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mem_arb_if #(.DATA_WIDTH(32)) bus1 ();
    mem_arb_if #(.DATA_WIDTH(32)) bus3 ();

    mem_arbiter #(.DATA_WIDTH(32), .RD_LAT(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mem_arbiter #(.DATA_WIDTH(32), .RD_LAT(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents: fixed pattern, with the test-plan word at 0x10.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hDEAD_BEEF;
        return a ^ 32'hA5A5_0000;
    endfunction

    // Memory models: data is valid only in the single cycle RD_LAT after mem_r_en.
    logic        pv1_q;
    logic [31:0] pa1_q;
    logic        pv3_q [0:2];
    logic [31:0] pa3_q [0:2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pv1_q <= 1'b0;
            pa1_q <= 32'h0;
            for (int i = 0; i < 3; i++) begin
                pv3_q[i] <= 1'b0;
                pa3_q[i] <= 32'h0;
            end
        end else begin
            pv1_q    <= bus1.mem_r_en;
            pa1_q    <= bus1.mem_r_addr;
            pv3_q[0] <= bus3.mem_r_en;
            pa3_q[0] <= bus3.mem_r_addr;
            pv3_q[1] <= pv3_q[0];
            pa3_q[1] <= pa3_q[0];
            pv3_q[2] <= pv3_q[1];
            pa3_q[2] <= pa3_q[1];
        end
    end

    assign bus1.mem_r_data = pv1_q    ? mem_fn(pa1_q)    : 32'hBAD0_BAD0;
    assign bus3.mem_r_data = pv3_q[2] ? mem_fn(pa3_q[2]) : 32'hBAD0_BAD0;

    typedef struct {
        logic        p0_req;
        logic [1:0]  p0_act;
        logic [31:0] p0_addr;
        logic [31:0] p0_wd;
        logic        p1_req;
        logic [1:0]  p1_act;
        logic [31:0] p1_addr;
        logic [31:0] p1_wd;
        logic [1:0]  e_gnt;   // {p1, p0}
        logic [1:0]  e_rv;    // {p1, p0}
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic p0r, input logic [1:0] p0a, input logic [31:0] p0ad,
                       input logic [31:0] p0wd, input logic p1r, input logic [1:0] p1a,
                       input logic [31:0] p1ad, input logic [31:0] p1wd,
                       input logic [1:0] gnt, input logic [1:0] rv, input logic ren,
                       input logic wen, input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] rd);
        vec_t v;
        v.p0_req = p0r; v.p0_act = p0a; v.p0_addr = p0ad; v.p0_wd = p0wd;
        v.p1_req = p1r; v.p1_act = p1a; v.p1_addr = p1ad; v.p1_wd = p1wd;
        v.e_gnt = gnt; v.e_rv = rv; v.e_ren = ren; v.e_wen = wen;
        v.e_addr = ad; v.e_wd = wd; v.e_rd = rd;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] ctl1();
        return {bus1.p1_gnt, bus1.p0_gnt, bus1.p1_rvalid, bus1.p0_rvalid,
                bus1.mem_r_en, bus1.mem_w_en};
    endfunction

    function automatic logic [5:0] ctl3();
        return {bus3.p1_gnt, bus3.p0_gnt, bus3.p1_rvalid, bus3.p0_rvalid,
                bus3.mem_r_en, bus3.mem_w_en};
    endfunction

    task automatic drive1(input vec_t v);
        bus1.p0_req = v.p0_req; bus1.p0_action = v.p0_act;
        bus1.p0_addr = v.p0_addr; bus1.p0_wdata = v.p0_wd;
        bus1.p1_req = v.p1_req; bus1.p1_action = v.p1_act;
        bus1.p1_addr = v.p1_addr; bus1.p1_wdata = v.p1_wd;
    endtask

    task automatic all_zero1(input string tag);
        chk({tag, " ctl"}, 64'(ctl1()), 64'h0);
        chk({tag, " r_addr"}, 64'(bus1.mem_r_addr), 64'h0);
        chk({tag, " w_addr"}, 64'(bus1.mem_w_addr), 64'h0);
        chk({tag, " w_data"}, 64'(bus1.mem_w_data), 64'h0);
        chk({tag, " rdata"}, 64'(bus1.rdata), 64'h0);
    endtask

    initial begin
        logic [31:0] rd_hold;
        logic [31:0] a;
        logic        w;
        vec_t        idle_v;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_v = '{p0_req: 1'b0, p0_act: 2'b00, p0_addr: 32'h0, p0_wd: 32'h0,
                   p1_req: 1'b0, p1_act: 2'b00, p1_addr: 32'h0, p1_wd: 32'h0,
                   e_gnt: 2'b00, e_rv: 2'b00, e_ren: 1'b0, e_wen: 1'b0,
                   e_addr: 32'h0, e_wd: 32'h0, e_rd: 32'h0};
        drive1(idle_v);
        bus3.p0_req = 1'b0; bus3.p0_action = 2'b00; bus3.p0_addr = 32'h0; bus3.p0_wdata = 32'h0;
        bus3.p1_req = 1'b0; bus3.p1_action = 2'b00; bus3.p1_addr = 32'h0; bus3.p1_wdata = 32'h0;

        // ---------------- vector table (RD_LAT=1 instance) ----------------
        add(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0,
            2'b00, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        // single read p0 @0x10
        add(1'b1, 2'b01, 32'h10, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0,
            2'b01, 2'b00, 1'b1, 1'b0, 32'h10, 32'h0, 32'h0);
        add(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0,
            2'b00, 2'b00, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0);
        add(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0,
            2'b00, 2'b01, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        // single write p1 @0x20
        add(1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2'b10, 32'h20, 32'h55AA,
            2'b10, 2'b00, 1'b0, 1'b1, 32'h20, 32'h55AA, 32'hDEAD_BEEF);
        add(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0,
            2'b00, 2'b00, 1'b0, 1'b0, 32'h20, 32'h55AA, 32'hDEAD_BEEF);
        add(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0,
            2'b00, 2'b00, 1'b0, 1'b0, 32'h20, 32'h55AA, 32'hDEAD_BEEF);
        // action 00 with req: ignored
        add(1'b1, 2'b00, 32'h77, 32'h99, 1'b0, 2'b00, 32'h0, 32'h0,
            2'b00, 2'b00, 1'b0, 1'b0, 32'h20, 32'h55AA, 32'hDEAD_BEEF);
        add(1'b1, 2'b00, 32'h77, 32'h99, 1'b0, 2'b00, 32'h0, 32'h0,
            2'b00, 2'b00, 1'b0, 1'b0, 32'h20, 32'h55AA, 32'hDEAD_BEEF);
        // action 11 on p1: write, no rvalid
        add(1'b1, 2'b00, 32'h77, 32'h99, 1'b1, 2'b11, 32'h30, 32'h1234,
            2'b10, 2'b00, 1'b0, 1'b1, 32'h30, 32'h1234, 32'hDEAD_BEEF);
        add(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0,
            2'b00, 2'b00, 1'b0, 1'b0, 32'h30, 32'h1234, 32'hDEAD_BEEF);
        add(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0,
            2'b00, 2'b00, 1'b0, 1'b0, 32'h30, 32'h1234, 32'hDEAD_BEEF);
        // contention: both read continuously; last grant was p1, so p0 goes first
        rd_hold = 32'hDEAD_BEEF;
        for (int k = 0; k < 4; k++) begin
            w = FIXED_PRIO ? 1'b1 : k[0];
            a = w ? 32'h200 : 32'h100;
            add(1'b1, 2'b01, 32'h100, 32'h0, 1'b1, 2'b01, 32'h200, 32'h0,
                w ? 2'b10 : 2'b01, 2'b00, 1'b1, 1'b0, a, 32'h0, rd_hold);
            add(1'b1, 2'b01, 32'h100, 32'h0, 1'b1, 2'b01, 32'h200, 32'h0,
                2'b00, 2'b00, 1'b0, 1'b0, a, 32'h0, rd_hold);
            rd_hold = mem_fn(a);
            add(1'b1, 2'b01, 32'h100, 32'h0, 1'b1, 2'b01, 32'h200, 32'h0,
                2'b00, w ? 2'b10 : 2'b01, 1'b0, 1'b0, a, 32'h0, rd_hold);
        end
        add(1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0,
            2'b00, 2'b00, 1'b0, 1'b0, a, 32'h0, rd_hold);

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        all_zero1("reset1");
        chk("reset3 ctl", 64'(ctl3()), 64'h0);
        chk("reset3 rdata", 64'(bus3.rdata), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- table loop ----------------
        foreach (vecs[i]) begin
            @(negedge clk);
            drive1(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d ctl", i), 64'(ctl1()),
                64'({vecs[i].e_gnt, vecs[i].e_rv, vecs[i].e_ren, vecs[i].e_wen}));
            chk($sformatf("vec%0d r_addr", i), 64'(bus1.mem_r_addr), 64'(vecs[i].e_addr));
            chk($sformatf("vec%0d w_addr", i), 64'(bus1.mem_w_addr), 64'(vecs[i].e_addr));
            chk($sformatf("vec%0d w_data", i), 64'(bus1.mem_w_data), 64'(vecs[i].e_wd));
            chk($sformatf("vec%0d rdata", i), 64'(bus1.rdata), 64'(vecs[i].e_rd));
        end

        // ---------------- reset during a read ----------------
        @(negedge clk);
        bus1.p0_req = 1'b1; bus1.p0_action = 2'b01; bus1.p0_addr = 32'h40; bus1.p0_wdata = 32'h0;
        @(posedge clk); #1;
        chk("midrst gnt", 64'(ctl1()), 64'(6'b010010));
        @(negedge clk);
        bus1.p0_req = 1'b0; bus1.p0_action = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        all_zero1("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            chk($sformatf("midrst quiet%0d", j), 64'(ctl1()), 64'h0);
        end
        @(negedge clk);
        bus1.p0_req = 1'b1; bus1.p0_action = 2'b01; bus1.p0_addr = 32'h10;
        @(posedge clk); #1;
        chk("postrst gnt", 64'(ctl1()), 64'(6'b010010));
        chk("postrst addr", 64'(bus1.mem_r_addr), 64'h10);
        @(negedge clk);
        bus1.p0_req = 1'b0; bus1.p0_action = 2'b00;
        @(posedge clk);
        @(posedge clk); #1;
        chk("postrst rvalid", 64'(ctl1()), 64'(6'b000100));
        chk("postrst rdata", 64'(bus1.rdata), 64'hDEAD_BEEF);

        // ---------------- RD_LAT=3 read ----------------
        @(negedge clk);
        bus3.p0_req = 1'b1; bus3.p0_action = 2'b01; bus3.p0_addr = 32'h10;
        @(posedge clk); #1;
        chk("lat3 gnt", 64'(ctl3()), 64'(6'b010010));
        chk("lat3 addr", 64'(bus3.mem_r_addr), 64'h10);
        @(negedge clk);
        bus3.p0_req = 1'b0; bus3.p0_action = 2'b00;
        for (int j = 2; j <= 4; j++) begin
            @(posedge clk); #1;
            chk($sformatf("lat3 wait T+%0d", j), 64'(ctl3()), 64'h0);
        end
        @(posedge clk); #1;
        chk("lat3 rvalid T+5", 64'(ctl3()), 64'(6'b000100));
        chk("lat3 rdata", 64'(bus3.rdata), 64'hDEAD_BEEF);
        @(posedge clk); #1;
        chk("lat3 after", 64'(ctl3()), 64'h0);
        chk("lat3 rdata hold", 64'(bus3.rdata), 64'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
